// File: rtl/oscillator_bank_pkg.sv
// oscillator_bank_pkg
// Shared types and constants for the oscillator bank: waveform selector,
// sweep FSM state encoding, audio clock constants and the sample-tick
// derivation used by the top level.
// Optional feature macro used elsewhere in the bundle: OSC_BANK_SATURATE_EN.
package oscillator_bank_pkg;

  localparam int CONFIG_AUDIO_CLOCK     = 16_934_400;
  localparam int CONFIG_AUDIO_BIT_WIDTH = 24;
  localparam int CONFIG_SAMPLE_RATE     = 44_100;

  localparam int DEFAULT_VOICES      = 8;
  localparam int DEFAULT_PHASE_WIDTH = 24;

  typedef enum logic [1:0] {
    SAW      = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    OFF      = 2'd3
  } waveform_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  function automatic int calc_sample_ticks(input int clock_hz, input int sample_rate);
    return clock_hz / sample_rate;
  endfunction

  localparam int SAMPLE_TICKS = calc_sample_ticks(CONFIG_AUDIO_CLOCK, CONFIG_SAMPLE_RATE);

endpackage

// File: rtl/oscillator_bank_if.sv
// oscillator_bank_if
// Groups the per-voice configuration and the mixed-sample output of the
// oscillator bank.
//   voice_enable    : per-voice enable, one bit per voice
//   voice_increment : per-voice phase increment, voice i at [i*PHASE_WIDTH +: PHASE_WIDTH]
//   voice_mode      : per-voice waveform_t, voice i at [i*2 +: 2]
//   sample_out      : signed mixed sample, held between updates
//   sample_valid    : one-cycle pulse when sample_out updates
// master = configuration source / sample consumer, slave = oscillator bank.
interface oscillator_bank_if #(
  parameter int VOICES      = 8,
  parameter int PHASE_WIDTH = 24,
  parameter int AUDIO_WIDTH = 24
);

  logic [VOICES-1:0]             voice_enable;
  logic [VOICES*PHASE_WIDTH-1:0] voice_increment;
  logic [VOICES*2-1:0]           voice_mode;
  logic signed [AUDIO_WIDTH-1:0] sample_out;
  logic                          sample_valid;

  modport master (
    output voice_enable, voice_increment, voice_mode,
    input  sample_out, sample_valid
  );

  modport slave (
    input  voice_enable, voice_increment, voice_mode,
    output sample_out, sample_valid
  );

endinterface

// File: rtl/oscillator_bank_waveform_shaper.sv
// waveform_shaper
// Combinational map from the top AUDIO_WIDTH bits of a voice phase to a
// signed sample. One instance is shared by all voices during the sweep.
//   i_p      : unsigned phase slice
//   i_mode   : waveform selector
//   o_sample : signed two's-complement sample
module waveform_shaper
  import oscillator_bank_pkg::*;
#(
  parameter int AUDIO_WIDTH = 24
) (
  input  logic [AUDIO_WIDTH-1:0]        i_p,
  input  waveform_t                     i_mode,
  output logic signed [AUDIO_WIDTH-1:0] o_sample
);

  logic [AUDIO_WIDTH-1:0] w_q;
  logic [AUDIO_WIDTH-1:0] w_tri;

  // Triangle: double the lower half-cycle ramp, fold on the second half.
  assign w_q   = {i_p[AUDIO_WIDTH-2:0], 1'b0};
  assign w_tri = i_p[AUDIO_WIDTH-1] ? ~w_q : w_q;

  // Inverting the MSB converts offset-binary to two's complement.
  always_comb begin
    o_sample = '0;
    case (i_mode)
      SAW:      o_sample = {~i_p[AUDIO_WIDTH-1], i_p[AUDIO_WIDTH-2:0]};
      SQUARE:   o_sample = {i_p[AUDIO_WIDTH-1], {(AUDIO_WIDTH-1){~i_p[AUDIO_WIDTH-1]}}};
      TRIANGLE: o_sample = {~w_tri[AUDIO_WIDTH-1], w_tri[AUDIO_WIDTH-2:0]};
      default:  o_sample = '0;
    endcase
  end

endmodule

// File: rtl/oscillator_bank.sv
// oscillator_bank
// Multi-voice phase-accumulator oscillator bank. A free-running tick counter
// derives the sample strobe from the audio master clock; each sample period
// the voices are visited one per cycle, their waveforms summed into a mix
// accumulator, and one normalised sample is emitted with a valid pulse.
// Ports:
//   clock_16_934_400 : sole clock, rising edge
//   reset            : synchronous, active-high
//   bus              : oscillator_bank_if slave (voice config in, sample out)
// Optional feature: OSC_BANK_SATURATE_EN -- output is the clamped full mix
// instead of the shifted (averaged) mix.
// Parameter constraints: 1 <= VOICES <= SAMPLE_TICKS-2, VOICES a power of
// two, PHASE_WIDTH >= AUDIO_WIDTH >= 2.
//
// state     | meaning
// ST_IDLE   | waiting for the tick counter to wrap
// ST_SWEEP  | visiting voice r_idx, accumulating and advancing its phase
// ST_OUTPUT | sample_out holds the new sample, sample_valid high
module oscillator_bank
  import oscillator_bank_pkg::*;
#(
  parameter int VOICES      = DEFAULT_VOICES,
  parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
  parameter int AUDIO_WIDTH = CONFIG_AUDIO_BIT_WIDTH,
  parameter int CLOCK_HZ    = CONFIG_AUDIO_CLOCK,
  parameter int SAMPLE_RATE = CONFIG_SAMPLE_RATE
) (
  input  logic              clock_16_934_400,
  input  logic              reset,
  oscillator_bank_if.slave  bus
);

  localparam int TICKS  = calc_sample_ticks(CLOCK_HZ, SAMPLE_RATE);
  localparam int TICK_W = $clog2(TICKS);
  localparam int SHIFT  = $clog2(VOICES);
  localparam int IDX_W  = (VOICES > 1) ? SHIFT : 1;
  localparam int MIX_W  = AUDIO_WIDTH + SHIFT;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(VOICES - 1);

  state_t                        r_state;
  state_t                        w_state_next;
  logic [TICK_W-1:0]             r_tick;
  logic [IDX_W-1:0]              r_idx;
  logic [PHASE_WIDTH-1:0]        r_phase [VOICES];
  logic signed [MIX_W-1:0]       r_mix;
  logic signed [AUDIO_WIDTH-1:0] r_sample_out;

  logic                          w_wrap;
  logic                          w_last_voice;
  logic                          w_start;
  logic                          w_sweep;
  logic                          w_valid;
  logic                          w_en;
  logic [1:0]                    w_mode_bits;
  waveform_t                     w_mode;
  logic [PHASE_WIDTH-1:0]        w_inc;
  logic [PHASE_WIDTH-1:0]        w_phase;
  logic signed [AUDIO_WIDTH-1:0] w_wave;
  logic signed [MIX_W-1:0]       w_contrib;
  logic signed [MIX_W-1:0]       w_mix_final;
  logic signed [AUDIO_WIDTH-1:0] w_out_next;

  assign w_wrap       = (r_tick == TICK_LAST);
  assign w_last_voice = (r_idx == IDX_LAST);

  // Select the configuration and phase of the voice being visited.
  always_comb begin
    w_en        = 1'b0;
    w_mode_bits = '0;
    w_inc       = '0;
    w_phase     = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_en        = bus.voice_enable[i];
        w_mode_bits = bus.voice_mode[i*2 +: 2];
        w_inc       = bus.voice_increment[i*PHASE_WIDTH +: PHASE_WIDTH];
        w_phase     = r_phase[i];
      end
    end
  end

  assign w_mode = waveform_t'(w_mode_bits);

  waveform_shaper #(
    .AUDIO_WIDTH (AUDIO_WIDTH)
  ) u_shaper (
    .i_p      (w_phase[PHASE_WIDTH-1 -: AUDIO_WIDTH]),
    .i_mode   (w_mode),
    .o_sample (w_wave)
  );

  assign w_contrib   = w_en ? MIX_W'(w_wave) : '0;
  // Includes the voice being visited, so the last sweep cycle can load
  // sample_out directly and the output stage only has to pulse valid.
  assign w_mix_final = r_mix + w_contrib;

`ifdef OSC_BANK_SATURATE_EN
  localparam logic signed [MIX_W-1:0] SAT_MAX =
    {{(MIX_W-AUDIO_WIDTH+1){1'b0}}, {(AUDIO_WIDTH-1){1'b1}}};
  localparam logic signed [MIX_W-1:0] SAT_MIN =
    {{(MIX_W-AUDIO_WIDTH+1){1'b1}}, {(AUDIO_WIDTH-1){1'b0}}};

  always_comb begin
    if (w_mix_final > SAT_MAX) begin
      w_out_next = AUDIO_WIDTH'(SAT_MAX);
    end else if (w_mix_final < SAT_MIN) begin
      w_out_next = AUDIO_WIDTH'(SAT_MIN);
    end else begin
      w_out_next = AUDIO_WIDTH'(w_mix_final);
    end
  end
`else
  // Dividing by the voice count keeps the result inside AUDIO_WIDTH.
  assign w_out_next = AUDIO_WIDTH'(w_mix_final >>> SHIFT);
`endif

  always_ff @(posedge clock_16_934_400) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_sweep      = 1'b0;
    w_valid      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wrap) begin
          w_start      = 1'b1;
          w_state_next = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        w_sweep = 1'b1;
        if (w_last_voice) begin
          w_state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        w_valid      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_16_934_400) begin
    if (reset) begin
      r_tick       <= '0;
      r_idx        <= '0;
      r_mix        <= '0;
      r_sample_out <= '0;
      for (int i = 0; i < VOICES; i++) begin
        r_phase[i] <= '0;
      end
    end else begin
      r_tick <= w_wrap ? '0 : r_tick + 1'b1;
      if (w_start) begin
        r_mix <= '0;
        r_idx <= '0;
      end else if (w_sweep) begin
        r_mix <= w_mix_final;
        r_idx <= r_idx + 1'b1;
        for (int i = 0; i < VOICES; i++) begin
          if (r_idx == IDX_W'(i)) begin
            r_phase[i] <= w_en ? (w_phase + w_inc) : '0;
          end
        end
        if (w_last_voice) begin
          r_sample_out <= w_out_next;
        end
      end
    end
  end

  assign bus.sample_out   = r_sample_out;
  assign bus.sample_valid = w_valid;

endmodule
